// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared types and defaults for the multicycle RISC-V memory side.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } mem_bridge_state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/rv_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_bridge_if
// Brief    : Request/grant/response memory bus between bridge and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_mem_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/rv_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : rv_timeout_cnt
// Brief    : Saturating cycle counter with clear, enable and expiry flag.
// Revision : 1.0 - initial release
// ============================================================================
module rv_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the last permitted cycle so the owner leaves after exactly LIMIT cycles.
  assign expired_o = (cnt_q == W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/rv_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_bridge
// Brief    : Latches one core access, runs it on the wait-state bus, times out.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_bridge
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_busy_o,
  output logic              core_valid_o,
  output logic              core_err_o,
  output logic [DATA_W-1:0] core_rdata_o,
  rv_mem_bridge_if.master   mem
);

  localparam logic [2:0] c_st_idle = IDLE;
  localparam logic [2:0] c_st_req  = REQ;
  localparam logic [2:0] c_st_resp = RESP;
  localparam logic [2:0] c_st_done = DONE;
  localparam logic [2:0] c_st_err  = ERR;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tmr_clr, tmr_en, tmr_expired;

  rv_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      c_st_idle: begin
        tmr_clr = 1'b1;
        if (core_req_i) begin
          we_d    = core_we_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          state_d = c_st_req;
        end
      end
      c_st_req: begin
        if (mem.mem_gnt && mem.mem_rvalid) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          state_d = c_st_done;
        end else if (mem.mem_gnt) begin
          tmr_clr = 1'b1;
          state_d = c_st_resp;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_d = c_st_err;
        end
      end
      c_st_resp: begin
        // Writes wait here too: rvalid doubles as the write acknowledge.
        if (mem.mem_rvalid) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          state_d = c_st_done;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_d = c_st_err;
        end
      end
      c_st_done: state_d = c_st_idle;
      c_st_err:  state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= c_st_idle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign core_busy_o   = (state_q != c_st_idle);
  assign core_valid_o  = (state_q == c_st_done) || (state_q == c_st_err);
  assign core_err_o    = (state_q == c_st_err);
  assign core_rdata_o  = rdata_q;
  assign mem.mem_req   = (state_q == c_st_req);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_bridge
// Brief    : Scenario bench for rv_mem_bridge with a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_bridge;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_busy, core_valid, core_err;
  logic [31:0] core_rdata;

  int   errors = 0;
  int   checks = 0;
  int   comps  = 0;
  exp_t exp_q[$];

  rv_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_busy_o  (core_busy),
    .core_valid_o (core_valid),
    .core_err_o   (core_err),
    .core_rdata_o (core_rdata),
    .mem          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && core_valid === 1'b1) begin
      exp_t e;
      comps++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL completion_unexpected: got err=%0b rdata=%h, none required", core_err, core_rdata);
      end else begin
        e = exp_q.pop_front();
        if (core_err !== e.err || core_rdata !== e.rdata) begin
          errors++;
          $display("FAIL completion: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   core_err, core_rdata, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    step(); step();
    checks++;
    if ({core_busy, core_valid, core_err, bus.mem_req, bus.mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/valid/err/req/we=%b, required 00000",
               {core_busy, core_valid, core_err, bus.mem_req, bus.mem_we});
    end
    checks++;
    if (core_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required all 0",
               core_rdata, bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_read();
    start_access(1'b0, 32'h40, 32'h0);
    step();
    core_req = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || core_busy !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL read_req: got req=%b busy=%b addr=%h we=%b, required 1 1 00000040 0",
               bus.mem_req, core_busy, bus.mem_addr, bus.mem_we);
    end
    bus.mem_gnt = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 32'h1234_5678});
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || core_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: got req=%b valid=%b, required 0 0", bus.mem_req, core_valid);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (core_valid !== 1'b1 || core_err !== 1'b0 || core_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_latency: got valid=%b err=%b rdata=%h in cycle 3, required 1 0 12345678",
               core_valid, core_err, core_rdata);
    end
    step();
    checks++;
    if (core_valid !== 1'b0 || core_busy !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse: got valid=%b busy=%b after completion, required 0 0", core_valid, core_busy);
    end
  endtask

  task automatic test_write_wait();
    int bad = 0;
    start_access(1'b1, 32'h100, 32'hA5A5_A5A5);
    step();
    core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 ||
          bus.mem_wdata !== 32'hA5A5_A5A5) bad++;
      if (i == 3) bus.mem_gnt = 1'b1;
      step();
    end
    bus.mem_gnt = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL write_stable: got %0d unstable request cycles, required 0", bad);
    end
    exp_q.push_back('{err: 1'b0, rdata: 32'h1234_5678});
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (core_valid !== 1'b1 || core_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_ack: got valid=%b rdata=%h, required 1 12345678", core_valid, core_rdata);
    end
    step();
  endtask

  task automatic test_same_cycle();
    start_access(1'b0, 32'h80, 32'h0);
    step();
    core_req = 1'b0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (core_valid !== 1'b1 || core_err !== 1'b0 || core_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL same_cycle: got valid=%b err=%b rdata=%h in cycle 2, required 1 0 cafef00d",
               core_valid, core_err, core_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    exp_q.push_back('{err: 1'b1, rdata: 32'hCAFE_F00D});
    start_access(1'b0, 32'hC0, 32'h0);
    step();
    core_req = 1'b0;
    while (bus.mem_req === 1'b1 && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d REQ cycles, required 4", n);
    end
    checks++;
    if (core_valid !== 1'b1 || core_err !== 1'b1 || core_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL timeout_err: got valid=%b err=%b rdata=%h, required 1 1 cafef00d",
               core_valid, core_err, core_rdata);
    end
    step();
    checks++;
    if (core_busy !== 1'b0 || core_valid !== 1'b0 || core_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b valid=%b err=%b, required 0 0 0", core_busy, core_valid, core_err);
    end
  endtask

  task automatic test_spurious();
    int c0 = comps;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (core_rdata !== 32'hCAFE_F00D || core_busy !== 1'b0 || core_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rvalid: got rdata=%h busy=%b valid=%b, required cafef00d 0 0",
               core_rdata, core_busy, core_valid);
    end
    start_access(1'b0, 32'h200, 32'h0);
    step();
    start_access(1'b1, 32'h300, 32'h5555_5555);
    bus.mem_gnt = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 32'h2222_2222});
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_ignored: got addr=%h we=%b, required 00000200 0", bus.mem_addr, bus.mem_we);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h2222_2222;
    step();
    core_req = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (comps - c0 !== 1) begin
      errors++;
      $display("FAIL single_completion: got %0d completions, required 1", comps - c0);
    end
  endtask

  task automatic test_reset_mid();
    start_access(1'b0, 32'h44, 32'h0);
    step();
    core_req = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({core_busy, core_valid, core_err, bus.mem_req, bus.mem_we} !== 5'b0 ||
        core_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy/valid/err/req/we=%b rdata=%h addr=%h, required all 0",
               {core_busy, core_valid, core_err, bus.mem_req, bus.mem_we}, core_rdata, bus.mem_addr);
    end
    rst = 1'b1;
    step();
    start_access(1'b0, 32'h48, 32'h0);
    step();
    core_req = 1'b0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0BAD_F00D});
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (core_valid !== 1'b1 || core_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL reset_recover: got valid=%b rdata=%h, required 1 0badf00d", core_valid, core_rdata);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_same_cycle();
    test_timeout();
    test_spurious();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding completions, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_mem_bridge.md
# rv_mem_bridge

Memory bridge for the multicycle RISC-V core. It sits between the control FSM / datapath memory port and a wait-state memory with request/grant/response handshake. It latches one core access, drives it onto the memory bus until it is granted and acknowledged, and returns read data with a single-cycle completion pulse. A timeout converts a hung bus into an error completion so the core FSM can never deadlock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles spent in REQ or RESP before error; legal range ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-low
- core_req  in  1  start access; sampled only in IDLE
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  access address
- core_wdata  in  DATA_W  write data
- core_busy  out  1  access in flight (state ≠ IDLE)
- core_valid  out  1  one-cycle completion pulse
- core_err  out  1  qualifies core_valid: access timed out
- core_rdata  out  DATA_W  last completed read data; held between reads
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response: read data valid or write acknowledged
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid

## Operation
- States: IDLE, REQ, RESP, DONE, ERR.
- IDLE: if core_req, latch we/addr/wdata into holding registers, clear timer, go to REQ. Otherwise stay.
- REQ: mem_req = 1; mem_we/addr/wdata come from the holding registers and stay stable until gnt.
  - mem_gnt & mem_rvalid in the same cycle: capture the response and go to DONE.
  - mem_gnt alone: clear timer and go to RESP.
  - Otherwise: increment timer. If timer == TIMEOUT-1, go to ERR.
- RESP: mem_req = 0.
  - mem_rvalid: if the access is a read, capture mem_rdata into core_rdata; go to DONE.
  - Otherwise: timer behaves as in REQ and goes to ERR on expiry.
- DONE: core_valid = 1, core_err = 0; next state is IDLE.
- ERR: core_valid = 1, core_err = 1; core_rdata is unchanged; next state is IDLE.
- Writes also wait for mem_rvalid as the write acknowledge. A write never modifies core_rdata.
- Events ignored:
  - core_req when not in IDLE.
  - mem_rvalid in IDLE, DONE or ERR (spurious responses).
  - mem_gnt outside REQ.
- Timer width is $clog2(TIMEOUT+1). The timer saturates and never wraps. REQ and RESP each last at most TIMEOUT cycles.

## Timing
- Reset (rst = 0 at a clock edge) forces IDLE and clears all holding registers, the timer and core_rdata. All outputs are 0 in reset, including mid-access; an in-flight bus transaction is abandoned.
- core_busy is registered-state decoded: it is high from the cycle after core_req is sampled until core_valid inclusive.
- Minimum latency, with gnt and rvalid in the same cycle: core_req sampled at edge 0, mem_req high in cycle 1, core_valid in cycle 2.
- Typical latency: gnt in cycle 1, rvalid in cycle 2, core_valid in cycle 3.
- core_rdata updates at the edge entering DONE, so it is valid while core_valid is high.
- A new core_req is accepted at earliest in the cycle after core_valid, i.e. back in IDLE.
- All outputs are functions of registered state or holding registers only. There is no combinational path from mem_* inputs to core_* or mem_* outputs.

## Structure
- The shared package rv_pkg holds:
  - the mem_bridge_state_t enum (IDLE=0, REQ=1, RESP=2, DONE=3, ERR=4);
  - the default TIMEOUT localparam.
- Sub-module rv_timeout_cnt: a parameterised saturating counter with clear, enable and an expired flag. It is reused later for fetch-side timeouts.
- The bridge itself contains the FSM, the holding registers and the rdata register.

## Test plan
- Read, gnt in cycle 1, rvalid+rdata=0x1234_5678 in cycle 2 -> core_valid in cycle 3; core_rdata=0x1234_5678, core_err=0.
- Write addr=0x100, wdata=0xA5A5_A5A5, gnt held low 3 cycles -> mem_req/addr/wdata stable through 4 cycles; after ack, core_valid pulses and core_rdata is unchanged.
- gnt and rvalid in the same cycle (rdata=0xCAFE_F00D) -> core_valid 2 cycles after core_req is sampled, with the new data.
- TIMEOUT=4, gnt never asserted -> 4 REQ cycles, then ERR: core_valid=1, core_err=1; back to IDLE.
- Spurious rvalid in IDLE and a second core_req while busy -> both ignored; core_rdata unchanged; exactly one completion.
- rst low during RESP -> next cycle IDLE with all outputs 0; a following read completes normally.
